clk_freq_meter: RTL and testbench

- Receiving-end companion to the team's clock divider.
- Samples a divided or slow clock (clk_in) as data in the clk_ref domain and measures its period in clk_ref cycles.
- Declares frequency lock after consecutive consistent periods, and flags loss of clock via timeout.
- Used to self-check divider outputs and gate downstream logic until the derived clock is stable.

---
 rtl/clk_freq_meter.sv | 166 ++++++++++++++++
 tb/tb_clk_freq_meter.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_freq_meter.sv
// Measures the rising-to-rising period of clk_in in clk_ref cycles, declares lock and flags clock loss (MEAS_DUTY_EN adds high_time).
// Latency: rise on clk_in reaches period/period_valid 3 clk_ref edges after clk_in is first sampled high; all outputs registered.
// Backpressure: none; period_valid and timeout are fire-and-forget single-cycle pulses.
module clk_freq_meter #(
    parameter int CNT_W       = 16,
    parameter int LOCK_CYCLES = 4,
    parameter int TOL         = 1
) (
    input  logic             clk_ref,
    input  logic             rst_n,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             locked,
    output logic             timeout
`ifdef MEAS_DUTY_EN
    ,
    output logic [CNT_W-1:0] high_time
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] TOL_V   = CNT_W'(TOL);
    localparam logic [7:0]       LOCK_V  = 8'(LOCK_CYCLES);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             prev_q, prev_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] ref_period_q, ref_period_d;
    logic [7:0]       match_cnt_q, match_cnt_d;
    state_e           state_q, state_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             period_valid_q, period_valid_d;
    logic             locked_q, locked_d;
    logic             timeout_q, timeout_d;

    logic             rise_det;
    logic [CNT_W-1:0] diff;
    logic             is_match;

    always_comb begin
        sync1_d        = clk_in;
        sync2_d        = sync1_q;
        prev_d         = sync2_q;
        rise_det       = sync2_q & ~prev_q;
        diff           = (cnt_q >= ref_period_q) ? (cnt_q - ref_period_q) : (ref_period_q - cnt_q);
        is_match       = (diff <= TOL_V);
        cnt_d          = cnt_q;
        ref_period_d   = ref_period_q;
        match_cnt_d    = match_cnt_q;
        state_d        = state_q;
        period_d       = period_q;
        period_valid_d = 1'b0;
        timeout_d      = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                // The first edge only starts the count; it has no period to report.
                if (rise_det) begin
                    state_d     = ACQ;
                    cnt_d       = CNT_ONE;
                    match_cnt_d = 8'd0;
                end
            end
            default: begin
                if (rise_det) begin
                    cnt_d          = CNT_ONE;
                    period_d       = cnt_q;
                    period_valid_d = 1'b1;
                    if (state_q == LOCKED) begin
                        if (!is_match) begin
                            state_d      = ACQ;
                            ref_period_d = cnt_q;
                            match_cnt_d  = 8'd1;
                        end
                    end else begin
                        if ((match_cnt_q == 8'd0) || !is_match) begin
                            ref_period_d = cnt_q;
                            match_cnt_d  = 8'd1;
                        end else begin
                            match_cnt_d = match_cnt_q + 8'd1;
                        end
                        if (match_cnt_d == LOCK_V) begin
                            state_d = LOCKED;
                        end
                    end
                end else if (cnt_q == CNT_MAX) begin
                    state_d     = IDLE;
                    cnt_d       = '0;
                    match_cnt_d = 8'd0;
                    timeout_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
        endcase

        locked_d = (state_d == LOCKED);
    end

`ifdef MEAS_DUTY_EN
    logic             fall_det;
    logic [CNT_W-1:0] high_time_q, high_time_d;

    always_comb begin
        fall_det    = ~sync2_q & prev_q;
        high_time_d = high_time_q;
        if ((state_q != IDLE) && fall_det) begin
            high_time_d = cnt_q;
        end
    end

    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            high_time_q <= '0;
        end else begin
            high_time_q <= high_time_d;
        end
    end

    assign high_time = high_time_q;
`endif

    always_ff @(posedge clk_ref) begin
        if (!rst_n) begin
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            prev_q         <= 1'b0;
            cnt_q          <= '0;
            ref_period_q   <= '0;
            match_cnt_q    <= 8'd0;
            state_q        <= IDLE;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            locked_q       <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            prev_q         <= prev_d;
            cnt_q          <= cnt_d;
            ref_period_q   <= ref_period_d;
            match_cnt_q    <= match_cnt_d;
            state_q        <= state_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            locked_q       <= locked_d;
            timeout_q      <= timeout_d;
        end
    end

    assign period       = period_q;
    assign period_valid = period_valid_q;
    assign locked       = locked_q;
    assign timeout      = timeout_q;

endmodule

// File: tb/tb_clk_freq_meter.sv
// Self-checking bench for clk_freq_meter: clk_in is driven as a sequence of high/low run lengths
// and a period-list model predicts every period_valid pulse together with the lock flag.
module tb_clk_freq_meter;

    localparam int CNT_W = 16;
    localparam int LOCK  = 4;
    localparam int TOL   = 1;
    localparam int MAXC  = 65535;

    logic             clk_ref;
    logic             rst_n;
    logic             clk_in;
    logic [CNT_W-1:0] period;
    logic             period_valid;
    logic             locked;
    logic             timeout;
`ifdef MEAS_DUTY_EN
    logic [CNT_W-1:0] high_time;
`endif

    clk_freq_meter #(.CNT_W(CNT_W), .LOCK_CYCLES(LOCK), .TOL(TOL)) dut (
        .clk_ref      (clk_ref),
        .rst_n        (rst_n),
        .clk_in       (clk_in),
        .period       (period),
        .period_valid (period_valid),
        .locked       (locked),
        .timeout      (timeout)
`ifdef MEAS_DUTY_EN
        ,
        .high_time    (high_time)
`endif
    );

    initial begin
        clk_ref = 1'b0;
        forever #5 clk_ref = ~clk_ref;
    end

    typedef struct {
        logic [31:0] p;
        logic        l;
    } ev_t;

    ev_t obs_q[$];
    ev_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  cyc      = 0;
    int  last_pv_cyc = 0;
    int  to_cyc   = 0;
    int  to_cnt   = 0;
    int  last_len = 0;

    // Model: list of measured periods -> lock decision, no knowledge of the pipeline.
    bit  m_has_edge = 1'b0;
    int  m_ref      = 0;
    int  m_run      = 0;
    bit  m_locked   = 1'b0;

    always @(posedge clk_ref) begin
        ev_t e;
        #1;
        cyc = cyc + 1;
        if (period_valid === 1'b1) begin
            e.p = {16'd0, period};
            e.l = locked;
            obs_q.push_back(e);
            last_pv_cyc = cyc;
        end
        if (timeout === 1'b1) begin
            to_cnt = to_cnt + 1;
            to_cyc = cyc;
        end
    end

    task automatic model_reset();
        m_has_edge = 1'b0;
        m_ref      = 0;
        m_run      = 0;
        m_locked   = 1'b0;
    endtask

    task automatic model_edge(input int p);
        int  pe;
        int  d;
        ev_t e;
        pe = (p > MAXC) ? MAXC : p;
        if (!m_has_edge) begin
            m_has_edge = 1'b1;
            m_run      = 0;
            m_locked   = 1'b0;
            return;
        end
        d = (pe > m_ref) ? pe - m_ref : m_ref - pe;
        if (m_locked) begin
            if (d > TOL) begin
                m_locked = 1'b0;
                m_ref    = pe;
                m_run    = 1;
            end
        end else begin
            if (m_run == 0 || d > TOL) begin
                m_ref = pe;
                m_run = 1;
            end else begin
                m_run = m_run + 1;
            end
            if (m_run == LOCK) m_locked = 1'b1;
        end
        e.p = 32'(pe);
        e.l = m_locked;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge that starts the next cycle.
    task automatic drive_cycle(input int h, input int l);
        clk_in = 1'b1;
        model_edge(last_len);
        repeat (h) @(negedge clk_ref);
        clk_in = 1'b0;
        repeat (l) @(negedge clk_ref);
        last_len = h + l;
    endtask

    task automatic test_reset();
        rst_n  = 1'b0;
        clk_in = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_ref);
            checks++;
            if (period !== 16'd0 || period_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold cyc%0d got p=%0d pv=%b lk=%b to=%b exp all 0", i, period, period_valid, locked, timeout);
            end
            clk_in = ~clk_in;
        end
        clk_in = 1'b0;
        @(negedge clk_ref);
        rst_n = 1'b1;
        repeat (3) @(negedge clk_ref);
        checks++;
        if (period !== 16'd0 || locked !== 1'b0 || obs_q.size() != 0 || to_cnt != 0) begin
            failures++;
            $display("FAIL reset_release got p=%0d lk=%b pulses=%0d timeouts=%0d exp 0", period, locked, obs_q.size(), to_cnt);
        end
        obs_q.delete();
        model_reset();
    endtask

    task automatic test_lock();
        for (int i = 0; i < 5; i++) drive_cycle(16, 16);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL lock_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.p !== e.p || o.l !== e.l) begin
                failures++;
                $display("FAIL lock_event got p=%0d lk=%b exp p=%0d lk=%b", o.p, o.l, e.p, e.l);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL lock_final got=%b exp=1", locked);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_jitter();
        int hs[8] = '{16, 16, 16, 17, 17, 17, 17, 16};
        int ls[8] = '{17, 15, 16, 18, 18, 18, 18, 16};
        for (int i = 0; i < 8; i++) drive_cycle(hs[i], ls[i]);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL jitter_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.p !== e.p || o.l !== e.l) begin
                failures++;
                $display("FAIL jitter_event got p=%0d lk=%b exp p=%0d lk=%b", o.p, o.l, e.p, e.l);
            end
        end
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL jitter_relock got=%b exp=1", locked);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random();
        int base;
        int len;
        int h;
        base = $urandom_range(10, 60);
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) base = $urandom_range(10, 60);
            len = base + $urandom_range(0, 2) - 1;
            h   = $urandom_range(2, len - 3);
            drive_cycle(h, len - h);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL random_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.p !== e.p || o.l !== e.l) begin
                failures++;
                $display("FAIL random_event got p=%0d lk=%b exp p=%0d lk=%b", o.p, o.l, e.p, e.l);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_timeout();
        int n;
        for (int i = 0; i < 5; i++) drive_cycle(10, 10);
        clk_in = 1'b1;
        model_edge(last_len);
        repeat (10) @(negedge clk_ref);
        clk_in = 1'b0;
        n = 0;
        while (to_cnt == 0 && n < 70000) begin
            @(negedge clk_ref);
            n++;
        end
        checks++;
        if (to_cnt == 0) begin
            failures++;
            $display("FAIL timeout_seen got=none within %0d cycles exp=pulse", n);
        end else begin
            checks++;
            if (to_cyc - last_pv_cyc != MAXC) begin
                failures++;
                $display("FAIL timeout_delay got=%0d exp=%0d", to_cyc - last_pv_cyc, MAXC);
            end
        end
        @(negedge clk_ref);
        checks++;
        if (locked !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL timeout_after got lk=%b to=%b exp 0 0", locked, timeout);
        end
        model_reset();
        for (int i = 0; i < 3; i++) drive_cycle(12, 12);
        checks++;
        if (to_cnt != 1) begin
            failures++;
            $display("FAIL timeout_pulses got=%0d exp=1", to_cnt);
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL timeout_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.p !== e.p || o.l !== e.l) begin
                failures++;
                $display("FAIL timeout_event got p=%0d lk=%b exp p=%0d lk=%b", o.p, o.l, e.p, e.l);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic test_reset_locked();
        for (int i = 0; i < 6; i++) drive_cycle(20, 20);
        checks++;
        if (locked !== 1'b1) begin
            failures++;
            $display("FAIL rstlk_prelock got=%b exp=1", locked);
        end
        obs_q.delete();
        exp_q.delete();
        rst_n = 1'b0;
        @(negedge clk_ref);
        rst_n = 1'b1;
        checks++;
        if (period !== 16'd0 || period_valid !== 1'b0 || locked !== 1'b0 || timeout !== 1'b0) begin
            failures++;
            $display("FAIL rstlk_clear got p=%0d pv=%b lk=%b to=%b exp all 0", period, period_valid, locked, timeout);
        end
        model_reset();
        for (int i = 0; i < 5; i++) drive_cycle(20, 20);
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL rstlk_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.p !== e.p || o.l !== e.l) begin
                failures++;
                $display("FAIL rstlk_event got p=%0d lk=%b exp p=%0d lk=%b", o.p, o.l, e.p, e.l);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask

`ifdef MEAS_DUTY_EN
    task automatic test_duty();
        for (int i = 0; i < 4; i++) begin
            drive_cycle(8, 24);
            checks++;
            if (high_time !== 16'd8) begin
                failures++;
                $display("FAIL duty_high cyc%0d got=%0d exp=8", i, high_time);
            end
        end
        checks++;
        if (obs_q.size() != exp_q.size()) begin
            failures++;
            $display("FAIL duty_count got=%0d exp=%0d", obs_q.size(), exp_q.size());
        end
        while (obs_q.size() > 0 && exp_q.size() > 0) begin
            ev_t o;
            ev_t e;
            o = obs_q.pop_front();
            e = exp_q.pop_front();
            checks++;
            if (o.p !== e.p || o.l !== e.l) begin
                failures++;
                $display("FAIL duty_event got p=%0d lk=%b exp p=%0d lk=%b", o.p, o.l, e.p, e.l);
            end
        end
        obs_q.delete();
        exp_q.delete();
    endtask
`endif

    initial begin
        rst_n  = 1'b0;
        clk_in = 1'b0;
        test_reset();
        test_lock();
        test_jitter();
        test_random();
        test_timeout();
        test_reset_locked();
`ifdef MEAS_DUTY_EN
        test_duty();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
